// File: rtl/arb_mux.sv
// Registered N-way arbitrating multiplexer: per-channel valid/ready/last inputs
// share one registered output stream, with packets kept contiguous by a lock.
module arb_mux #(
    parameter int switch_bits = 2,
    parameter int data_width  = 8,
    parameter int arb_mode    = 0,
    localparam int n_cell     = 1 << switch_bits
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [n_cell-1:0]            in_valid,
    input  logic [n_cell*data_width-1:0] in_data,
    input  logic [n_cell-1:0]            in_last,
    output logic [n_cell-1:0]            in_ready,
    output logic                         out_valid,
    output logic [data_width-1:0]        out_data,
    output logic                         out_last,
    output logic [switch_bits-1:0]       out_sel,
    input  logic                         out_ready
);

    logic                   out_valid_q, out_valid_d;
    logic [data_width-1:0]  out_data_q,  out_data_d;
    logic                   out_last_q,  out_last_d;
    logic [switch_bits-1:0] out_sel_q,   out_sel_d;
    logic [switch_bits-1:0] ptr_q,       ptr_d;
    logic                   locked_q,    locked_d;
    logic [switch_bits-1:0] lock_sel_q,  lock_sel_d;

    logic                   load;
    logic                   gnt_any;
    logic [switch_bits-1:0] gnt_idx;
    logic [switch_bits-1:0] cand;
    logic [n_cell-1:0]      grant;
    logic                   xfer;
    logic [data_width-1:0]  sel_data;
    logic                   sel_last;

    assign load = !out_valid_q || out_ready;

    // Searches run from the far end so the nearest candidate overwrites last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (locked_q) begin
            gnt_any = in_valid[lock_sel_q];
            gnt_idx = lock_sel_q;
        end else if (arb_mode == 1) begin
            for (int unsigned i = n_cell; i > 0; i--) begin
                if (in_valid[i-1]) begin
                    gnt_any = 1'b1;
                    gnt_idx = switch_bits'(i - 1);
                end
            end
        end else begin
            for (int unsigned k = n_cell; k > 0; k--) begin
                cand = ptr_q + switch_bits'(k - 1);
                if (in_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        grant    = '0;
        sel_data = '0;
        sel_last = 1'b0;
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
        for (int unsigned i = 0; i < n_cell; i++) begin
            if (gnt_any && gnt_idx == switch_bits'(i)) begin
                sel_data = in_data[i*data_width +: data_width];
                sel_last = in_last[i];
            end
        end
    end

    assign xfer     = load && gnt_any;
    assign in_ready = (rst_n && load) ? grant : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        locked_d    = locked_q;
        lock_sel_d  = lock_sel_q;
        if (load) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_data_d = sel_data;
            out_last_d = sel_last;
            out_sel_d  = gnt_idx;
            locked_d   = !sel_last;
            if (!sel_last) begin
                lock_sel_d = gnt_idx;
            end
            if (arb_mode == 0 && sel_last) begin
                ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
            locked_q    <= 1'b0;
            lock_sel_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
            locked_q    <= locked_d;
            lock_sel_q  <= lock_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule
